wb_sram_slave: RTL

- Wishbone classic responder: the slave end of the bus the data cache and LSU master.
- Backs a single-port 32-bit data RAM with byte-lane writes, a configurable wait-state count and an error response for out-of-range addresses.
- Sits on the data interconnect behind the cached region; also used standalone in core testbenches as the data memory.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/sram_bytewrite.sv | 36 +++
 rtl/wb_sram_slave.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone slave types, lane-select constants and the lane/alignment legality check.
package wb_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} wb_slv_state_t;

    localparam logic [3:0] WB_SEL_BYTE = 4'b0001;
    localparam logic [3:0] WB_SEL_HALF = 4'b0011;
    localparam logic [3:0] WB_SEL_WORD = 4'b1111;

    // Single bytes may sit anywhere; halves need even addresses; words need word alignment.
    function automatic logic wb_sel_legal(input logic [3:0] sel, input logic [1:0] adr_lo);
        logic legal;
        legal = 1'b0;
        case (sel)
            WB_SEL_BYTE, 4'b0010, 4'b0100, 4'b1000: legal = 1'b1;
            WB_SEL_HALF, 4'b1100:                   legal = ~adr_lo[0];
            WB_SEL_WORD:                            legal = (adr_lo == 2'b00);
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/sram_bytewrite.sv
// Single-port 32-bit RAM with synchronous read and per-byte write enables.
// Read data is held until the next read; the array itself is never reset.
module sram_bytewrite #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter string       INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rstn_i,
    input  logic          i_re,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (i_we[n]) r_mem[i_addr][8*n +: 8] <= i_wdata[8*n +: 8];
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rdata <= 32'h0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic SRAM responder with wait states and out-of-range error termination.
// Optional WB_SRAM_MISALIGN_ERR_EN also errors on misaligned or illegal lane patterns.
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned N_WORDS     = 7168,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int unsigned AW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    wb_slv_state_t r_state, w_state_d;
    logic [3:0]    r_cnt, w_cnt_d;
    logic          r_we, r_ack, r_err;
    logic [3:0]    r_sel;
    logic [31:0]   r_adr, r_dat;

    logic        w_req, w_idle, w_we, w_in_range, w_misalign, w_ok, w_go;
    logic [3:0]  w_sel;
    logic [31:0] w_adr, w_dat, w_idx;

    assign w_req  = wb_cyc_i & wb_stb_i;
    assign w_idle = (r_state == IDLE);

    // With no wait states the access happens on the accepting edge, so use the live bus.
    assign w_we  = w_idle ? wb_we_i  : r_we;
    assign w_sel = w_idle ? wb_sel_i : r_sel;
    assign w_adr = w_idle ? wb_adr_i : r_adr;
    assign w_dat = w_idle ? wb_dat_i : r_dat;

    assign w_idx      = (w_adr - BASE_ADDR) >> 2;
    assign w_in_range = (w_adr >= BASE_ADDR) && (w_idx < N_WORDS);

`ifdef WB_SRAM_MISALIGN_ERR_EN
    assign w_misalign = ~wb_sel_legal(w_sel, w_adr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_ok = w_in_range & ~w_misalign;
    assign w_go = (w_state_d == RESP);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (WAIT_CYCLES > 0) begin
                        w_state_d = WAIT;
                        w_cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        w_state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (!w_req) begin
                    w_state_d = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_d = RESP;
                end else begin
                    w_cnt_d = r_cnt - 4'd1;
                end
            end
            RESP:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 4'h0;
            r_adr   <= 32'h0;
            r_dat   <= 32'h0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_ack   <= w_go & w_ok;
            r_err   <= w_go & ~w_ok;
            if (w_idle && w_req) begin
                r_we  <= wb_we_i;
                r_sel <= wb_sel_i;
                r_adr <= wb_adr_i;
                r_dat <= wb_dat_i;
            end
        end
    end

    sram_bytewrite #(
        .DEPTH     (N_WORDS),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .rstn_i  (rstn_i),
        .i_re    (w_go & w_ok & ~w_we),
        .i_we    (w_sel & {4{w_go & w_ok & w_we}}),
        .i_addr  (w_idx[AW-1:0]),
        .i_wdata (w_dat),
        .o_rdata (wb_dat_o)
    );

    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;

endmodule
